// File: rtl/trace_pkg.sv
// Shared types and default widths for the trace feeder: FSM state encoding and bus widths.
package trace_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned CNT_W   = 20;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWaitAck,
    StWaitRel
  } state_e;

endpackage

// File: rtl/trace_feeder.sv
// Trace feeder: streams addresses from a 1-cycle-latency trace ROM to the cache with a
// four-phase trace_ready/updated handshake. Optional watchdog: TRACE_FEEDER_TIMEOUT_EN.
module trace_feeder #(
  parameter int unsigned ADDR_W      = trace_pkg::ADDR_W,
  parameter int unsigned DEPTH_W     = trace_pkg::DEPTH_W,
  parameter int unsigned CNT_W       = trace_pkg::CNT_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DEPTH_W-1:0] trace_len,
  output logic [DEPTH_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0]  rom_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               trace_ready,
  input  logic               updated,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued_count,
  output logic               timeout
);
  import trace_pkg::*;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] len_q, len_d;
  logic [DEPTH_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef TRACE_FEEDER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rom_addr_d = rom_addr_q;
    mem_addr_d = mem_addr_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
`ifdef TRACE_FEEDER_TIMEOUT_EN
    timeout_d  = timeout_q;
    tmo_d      = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef TRACE_FEEDER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (trace_len != '0) begin
            len_d      = trace_len;
            rom_addr_d = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        mem_addr_d = rom_data;
        ready_d    = 1'b1;
        state_d    = StWaitAck;
      end
      StWaitAck: begin
        if (updated) begin
          ready_d    = 1'b0;
          cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = StWaitRel;
        end
      end
      StWaitRel: begin
        if (!updated) begin
          if (cnt_q == CNT_W'(len_q)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef TRACE_FEEDER_TIMEOUT_EN
    // Watchdog only fires while the handshake is stalled; a real transition wins.
    if ((state_q == StWaitAck || state_q == StWaitRel) && state_d == state_q) begin
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        timeout_d = 1'b1;
        ready_d   = 1'b0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      rom_addr_q <= '0;
      mem_addr_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rom_addr_q <= rom_addr_d;
      mem_addr_q <= mem_addr_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef TRACE_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  assign rom_addr     = rom_addr_q;
  assign mem_addr     = mem_addr_q;
  assign trace_ready  = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_trace_feeder.sv
// Scoreboard bench for trace_feeder: directed runs push expected addresses/completions,
// an independent monitor pops and compares as the DUT presents them.
module tb_trace_feeder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] trace_len;
  logic [DW-1:0] rom_addr;
  logic [AW-1:0] rom_data;
  logic [AW-1:0] mem_addr;
  logic          trace_ready;
  logic          updated;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued_count;
  logic          timeout;

  always #5 clk = ~clk;

  trace_feeder #(
    .ADDR_W      (AW),
    .DEPTH_W     (DW),
    .CNT_W       (CW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .trace_len    (trace_len),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .mem_addr     (mem_addr),
    .trace_ready  (trace_ready),
    .updated      (updated),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count),
    .timeout      (timeout)
  );

  logic [AW-1:0] rom [0:15];
  always_ff @(posedge clk) rom_data <= rom[rom_addr[3:0]];

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_q[$];
  int            exp_done_q[$];
  int            run_len   = 0;
  int            ack_delay = 1;
  int            ack_limit = 1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Cache-side responder: raise updated ack_delay cycles after trace_ready, drop one cycle later.
  initial begin
    updated = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && trace_ready && !updated && int'(issued_count) < ack_limit) begin
        repeat (ack_delay - 1) @(negedge clk);
        updated = 1'b1;
        @(negedge clk);
        updated = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic          prev_ready;
    logic          prev_done;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_rom;
    int            e;
    prev_ready = 1'b0;
    prev_done  = 1'b0;
    held_addr  = '0;
    held_rom   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ready = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (trace_ready && !prev_ready) begin
          if (exp_addr_q.size() == 0) fail_now("unexpected_request");
          else check("mem_addr", mem_addr, exp_addr_q.pop_front());
          check("busy_in_run", busy, 1'b1);
          held_addr = mem_addr;
          held_rom  = rom_addr;
        end else if (trace_ready) begin
          check("mem_addr_stable", mem_addr, held_addr);
          check("rom_addr_stable", rom_addr, held_rom);
        end
        if (done) begin
          check("done_single_pulse", prev_done, 1'b0);
          check("busy_at_done", busy, 1'b0);
          if (exp_done_q.size() == 0) fail_now("unexpected_done");
          else begin
            e = exp_done_q.pop_front();
            if (e >= 0) check("issued_count_at_done", issued_count, e);
          end
        end
        if (busy) check("rom_addr_bound", rom_addr <= DW'(run_len), 1'b1);
        prev_ready = trace_ready;
        prev_done  = done;
      end
    end
  end

  task automatic pulse_start(input int len);
    @(negedge clk);
    trace_len = DW'(len);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
  endtask

  task automatic push_run(input int len);
    for (int i = 0; i < len; i++) exp_addr_q.push_back(rom[i]);
    exp_done_q.push_back(len);
    run_len = len;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom[i] = 32'hA000_0000 + 32'(i);
    rom[0] = 32'h0000_1000;
    rom[1] = 32'h0000_2010;
    rom[2] = 32'h0000_3FF0;
    reset     = 1'b1;
    start     = 1'b0;
    trace_len = '0;
    #12;
    check("reset_rom_addr", rom_addr, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_outputs", {trace_ready, busy, done, timeout}, 4'b0);
    check("reset_issued_count", issued_count, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Basic three-entry run with a 1-cycle responder
    push_run(3);
    pulse_start(3);
    check("busy_after_start", busy, 1'b1);
    wait_done(100, "run3_done");
    @(negedge clk);
    check("run3_count_held", issued_count, 3);
    check("run3_busy_low", busy, 1'b0);
    check("run3_mem_addr_held", mem_addr, 32'h0000_3FF0);

    // Slow responder: request must stay stable for the whole wait
    ack_delay = 10;
    push_run(2);
    pulse_start(2);
    wait_done(200, "slow_done");
    check("slow_count", issued_count, 2);
    ack_delay = 1;

    // Zero-length start
    exp_done_q.push_back(-1);
    @(negedge clk);
    trace_len = '0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    check("zero_len_done", done, 1'b1);
    check("zero_len_busy", busy, 1'b0);
    check("zero_len_ready", trace_ready, 1'b0);
    @(negedge clk);
    check("zero_len_done_cleared", done, 1'b0);
    check("zero_len_ready_after", trace_ready, 1'b0);

    // Start while busy is ignored
    push_run(3);
    pulse_start(3);
    repeat (3) @(negedge clk);
    trace_len = DW'(5);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_done(100, "ignored_start_done");
    check("ignored_start_count", issued_count, 3);
    repeat (6) @(negedge clk);

    // Reset in WAIT_ACK of entry 2
    ack_limit = 1;
    push_run(3);
    pulse_start(3);
    n = 0;
    while (!(trace_ready && issued_count == 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_entry2_wait", trace_ready && issued_count == 1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_outputs", {trace_ready, busy, done, timeout}, 4'b0);
    check("midrun_reset_rom_addr", rom_addr, 0);
    check("midrun_reset_mem_addr", mem_addr, 0);
    check("midrun_reset_count", issued_count, 0);
    exp_addr_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    ack_limit = 1000;
    push_run(2);
    pulse_start(2);
    wait_done(100, "post_reset_done");
    check("post_reset_count", issued_count, 2);

`ifdef TRACE_FEEDER_TIMEOUT_EN
    // Responder silent: watchdog must end the run
    ack_limit = 0;
    exp_addr_q.push_back(rom[0]);
    exp_done_q.push_back(0);
    run_len = 1;
    pulse_start(1);
    n = 0;
    while (!trace_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_ready_rose", trace_ready, 1'b1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_done_latency", n, 16);
    check("tmo_flag", timeout, 1'b1);
    check("tmo_ready_dropped", trace_ready, 1'b0);
    ack_limit = 1000;
    push_run(1);
    pulse_start(1);
    check("tmo_cleared_on_start", timeout, 1'b0);
    wait_done(100, "tmo_recovery_done");
`else
    check("timeout_tied_low", timeout, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
